// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480 timing constants, counter widths, lock states and CRC-16 helpers.
package vga_timing_pkg;
    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int WL        = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int WF        = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int X_W       = $clog2(WL);
    localparam int Y_W       = $clog2(WF);
    localparam int TO_W      = $clog2(2 * WL);
    localparam int PY_W      = 9;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} lock_state_t;

    // MSB-first CRC-16-CCITT advanced by one 12-bit {r,g,b} pixel
    function automatic logic [15:0] crc16_12(input logic [15:0] crc, input logic [11:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 11; i >= 0; i--) c = {c[14:0], 1'b0} ^ ((c[15] ^ data[i]) ? CRC_POLY : 16'h0000);
        return c;
    endfunction
endpackage

// File: rtl/vga_crc16.sv
// vga_crc16: CRC-16-CCITT accumulator taking one 12-bit pixel per enabled cycle; init wins over enable.
module vga_crc16
    import vga_timing_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_init,
    input  logic        i_en,
    input  logic [11:0] i_data,
    output logic [15:0] o_crc
);
    logic [15:0] r_crc;

    always_ff @(posedge clk) begin
        if (rst || i_init) r_crc <= CRC_INIT;
        else if (i_en)     r_crc <= crc16_12(r_crc, i_data);
    end

    assign o_crc = r_crc;
endmodule

// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: recovers pixel position from hsync/vsync, locks to VGA timing, counts frames/errors.
// Optional per-frame CRC of visible pixels when VGA_MON_CRC_EN is defined.
module vga_sync_monitor
    import vga_timing_pkg::*;
#(
    parameter int H_VIS = H_VISIBLE,
    parameter int H_FP  = H_FRONT,
    parameter int H_SW  = H_SYNC,
    parameter int H_BP  = H_BACK,
    parameter int V_VIS = V_VISIBLE,
    parameter int V_FP  = V_FRONT,
    parameter int V_SW  = V_SYNC,
    parameter int V_BP  = V_BACK
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_hsync_n,
    input  logic            i_vsync_n,
    input  logic [3:0]      i_r,
    input  logic [3:0]      i_g,
    input  logic [3:0]      i_b,
    output logic            o_pix_valid,
    output logic [X_W-1:0]  o_pix_x,
    output logic [PY_W-1:0] o_pix_y,
    output logic [3:0]      o_pix_r,
    output logic [3:0]      o_pix_g,
    output logic [3:0]      o_pix_b,
    output logic            o_locked,
    output logic            o_frame_start,
    output logic [15:0]     o_frame_count,
    output logic [7:0]      o_err_count,
    output logic            o_sync_err
`ifdef VGA_MON_CRC_EN
    ,
    output logic [15:0]     o_frame_crc,
    output logic            o_crc_valid
`endif
);
    localparam int LW = H_VIS + H_FP + H_SW + H_BP;
    localparam int LF = V_VIS + V_FP + V_SW + V_BP;
    localparam logic [X_W-1:0]  X_LAST = X_W'(LW - 1);
    localparam logic [X_W-1:0]  X_VIS  = X_W'(H_VIS);
    localparam logic [X_W-1:0]  X_HF   = X_W'(H_VIS + H_FP);
    localparam logic [X_W-1:0]  X_HR   = X_W'(H_VIS + H_FP + H_SW);
    localparam logic [Y_W-1:0]  Y_LAST = Y_W'(LF - 1);
    localparam logic [Y_W-1:0]  Y_VIS  = Y_W'(V_VIS);
    localparam logic [Y_W-1:0]  Y_VF   = Y_W'(V_VIS + V_FP);
    localparam logic [Y_W-1:0]  Y_VR   = Y_W'(V_VIS + V_FP + V_SW);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(2 * LW - 1);

    logic            r_hs, r_vs, r_hs_d, r_vs_d, r_hs_seen;
    logic [11:0]     r_rgb;
    logic [X_W-1:0]  r_x, w_x_pred, w_x;
    logic [Y_W-1:0]  r_y, w_y_pred, w_y;
    logic [TO_W-1:0] r_to;
    logic            w_hs_fall, w_hs_rise, w_vs_fall, w_vs_rise, w_x_wrap, w_to, w_err, w_valid, w_frame;
    lock_state_t     r_state, w_next;

    assign w_hs_fall = r_hs_d & ~r_hs;
    assign w_hs_rise = ~r_hs_d & r_hs;
    assign w_vs_fall = r_vs_d & ~r_vs;
    assign w_vs_rise = ~r_vs_d & r_vs;
    // r_x/r_y hold the position of the previous stage-1 sample; w_x/w_y describe the current one
    assign w_x_wrap  = r_x == X_LAST;
    assign w_x_pred  = w_x_wrap ? '0 : r_x + 1'b1;
    assign w_y_pred  = w_x_wrap ? ((r_y == Y_LAST) ? '0 : r_y + 1'b1) : r_y;
    assign w_x       = w_hs_fall ? X_HF : w_x_pred;
    assign w_y       = w_vs_fall ? Y_VF : w_y_pred;
    assign w_to      = (r_to == TO_MAX) && !w_hs_fall;
    assign w_err     = (w_hs_fall && w_x_pred != X_HF) || (w_hs_rise && w_x != X_HR) ||
                       (w_vs_fall && w_y_pred != Y_VF) || (w_vs_rise && w_y != Y_VR) || w_to;
    assign w_valid   = (r_state == LOCKED) && (w_x < X_VIS) && (w_y < Y_VIS);
    assign w_frame   = w_vs_fall && (r_state == LOCKED || w_next == LOCKED);
    assign o_locked  = r_state == LOCKED;

    always_comb begin
        w_next = r_state;
        case (r_state)
            UNLOCKED: w_next = (w_vs_fall && (r_hs_seen || w_hs_fall)) ? ACQUIRE : UNLOCKED;
            ACQUIRE:  w_next = w_err ? UNLOCKED : (w_vs_fall ? LOCKED : ACQUIRE);
            LOCKED:   w_next = w_err ? UNLOCKED : LOCKED;
            default:  w_next = UNLOCKED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {r_hs, r_vs, r_hs_d, r_vs_d} <= 4'hF;
            r_hs_seen     <= 1'b0;
            r_rgb         <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_to          <= '0;
            r_state       <= UNLOCKED;
            o_pix_valid   <= 1'b0;
            o_pix_x       <= '0;
            o_pix_y       <= '0;
            {o_pix_r, o_pix_g, o_pix_b} <= '0;
            o_frame_start <= 1'b0;
            o_frame_count <= '0;
            o_err_count   <= '0;
            o_sync_err    <= 1'b0;
        end else begin
            {r_hs, r_vs} <= {i_hsync_n, i_vsync_n};
            {r_hs_d, r_vs_d} <= {r_hs, r_vs};
            r_rgb         <= {i_r, i_g, i_b};
            r_hs_seen     <= (r_state == UNLOCKED) && (r_hs_seen || w_hs_fall);
            r_x           <= w_x;
            r_y           <= w_y;
            r_to          <= (w_hs_fall || w_to) ? '0 : r_to + 1'b1;
            r_state       <= w_next;
            o_pix_valid   <= w_valid;
            o_pix_x       <= w_x;
            o_pix_y       <= w_y[PY_W-1:0];
            {o_pix_r, o_pix_g, o_pix_b} <= r_rgb;
            o_frame_start <= w_frame;
            o_frame_count <= o_frame_count + {15'd0, w_frame};
            o_sync_err    <= w_err && (r_state != UNLOCKED);
            if (w_err && r_state == LOCKED && o_err_count != 8'hFF) o_err_count <= o_err_count + 1'b1;
        end
    end

`ifdef VGA_MON_CRC_EN
    logic [15:0] w_crc;
    logic        w_crc_evt;

    // frame boundary for the CRC is the first locked sample of row V_VIS
    assign w_crc_evt = (r_state == LOCKED) && (w_y == Y_VIS) && (r_y != Y_VIS);

    vga_crc16 u_crc (
        .clk    (clk),
        .rst    (rst),
        .i_init (w_crc_evt || r_state != LOCKED),
        .i_en   (w_valid),
        .i_data (r_rgb),
        .o_crc  (w_crc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            o_frame_crc <= '0;
            o_crc_valid <= 1'b0;
        end else begin
            o_crc_valid <= w_crc_evt;
            if (w_crc_evt) o_frame_crc <= w_crc;
        end
    end
`endif
endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb_vga_sync_monitor: directed checks of lock, pixel recovery, errors, timeout and reset on a scaled-down raster.
module tb_vga_sync_monitor;
    localparam int HV = 16, HF = 4, HS = 8, HB = 4, VV = 24, VF = 2, VS = 2, VB = 3;
    localparam int LW = HV + HF + HS + HB;
    localparam int LF = VV + VF + VS + VB;

    logic        clk = 1'b0, rst = 1'b1;
    logic        hsync_n = 1'b1, vsync_n = 1'b1;
    logic [3:0]  r_in = '0, g_in = '0, b_in = '0;
    logic        pix_valid, locked, frame_start, sync_err;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [3:0]  pix_r, pix_g, pix_b;
    logic [15:0] frame_count;
    logic [7:0]  err_count;
`ifdef VGA_MON_CRC_EN
    logic [15:0] frame_crc;
    logic        crc_valid;
`endif

    int sx = 0, sy = 0, lx = 0, ly = 0, hd_y = -1;
    bit hhold = 1'b0, solid = 1'b0;
    logic [11:0] scol = '0;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    vga_sync_monitor #(
        .H_VIS(HV), .H_FP(HF), .H_SW(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SW(VS), .V_BP(VB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_hsync_n     (hsync_n),
        .i_vsync_n     (vsync_n),
        .i_r           (r_in),
        .i_g           (g_in),
        .i_b           (b_in),
        .o_pix_valid   (pix_valid),
        .o_pix_x       (pix_x),
        .o_pix_y       (pix_y),
        .o_pix_r       (pix_r),
        .o_pix_g       (pix_g),
        .o_pix_b       (pix_b),
        .o_locked      (locked),
        .o_frame_start (frame_start),
        .o_frame_count (frame_count),
        .o_err_count   (err_count),
        .o_sync_err    (sync_err)
`ifdef VGA_MON_CRC_EN
        ,
        .o_frame_crc   (frame_crc),
        .o_crc_valid   (crc_valid)
`endif
    );

    function automatic logic [11:0] pcol(input int x, input int y);
        return 12'(x * 37 + y * 11);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // drive one raster sample, then step past the clock edge that captures it
    task automatic cyc();
        int hd;
        hd = (sy == hd_y) ? 1 : 0;
        hsync_n = hhold || !(sx >= HV + HF + hd && sx < HV + HF + HS + hd);
        vsync_n = !(sy >= VV + VF && sy < VV + VF + VS);
        {r_in, g_in, b_in} = solid ? scol : pcol(sx, sy);
        lx = sx;
        ly = sy;
        @(posedge clk);
        #1;
        sx = (sx == LW - 1) ? 0 : sx + 1;
        if (sx == 0) sy = (sy == LF - 1) ? 0 : sy + 1;
    endtask

    task automatic run_to(input int tx, input int ty);
        for (int i = 0; i < 2 * LW * LF; i++) begin
            cyc();
            if (lx == tx && ly == ty) return;
        end
        n_chk++;
        n_fail++;
        $error("FAIL run_to: observed no sample (%0d,%0d) expected one", tx, ty);
    endtask

    task automatic chk_pix(input string tag, input bit v, input int x, input int y, input logic [11:0] c);
        chk({tag, "_valid"}, 32'(pix_valid), 32'(v));
        chk({tag, "_x"}, 32'(pix_x), 32'(x));
        chk({tag, "_y"}, 32'(pix_y), 32'(y));
        chk({tag, "_rgb"}, 32'({pix_r, pix_g, pix_b}), 32'(c));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(pix_valid), 32'd0);
        chk({tag, "_x"}, 32'(pix_x), 32'd0);
        chk({tag, "_y"}, 32'(pix_y), 32'd0);
        chk({tag, "_rgb"}, 32'({pix_r, pix_g, pix_b}), 32'd0);
        chk({tag, "_locked"}, 32'(locked), 32'd0);
        chk({tag, "_fstart"}, 32'(frame_start), 32'd0);
        chk({tag, "_fcount"}, 32'(frame_count), 32'd0);
        chk({tag, "_ecount"}, 32'(err_count), 32'd0);
        chk({tag, "_serr"}, 32'(sync_err), 32'd0);
    endtask

`ifdef VGA_MON_CRC_EN
    function automatic logic [15:0] crc_ref(input int n, input logic [11:0] d);
        logic [15:0] c = 16'hFFFF;
        for (int p = 0; p < n; p++) begin
            c ^= {d, 4'h0};
            for (int b = 0; b < 12; b++) c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
        end
        return c;
    endfunction
`endif

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;

        // acquire on the first vsync fall, lock on the second
        run_to(0, VV + VF);
        cyc();
        chk("acq_locked", 32'(locked), 32'd0);
        chk("acq_fcount", 32'(frame_count), 32'd0);
        run_to(0, VV + VF);
        chk("pre_lock", 32'(locked), 32'd0);
        cyc();
        chk("lock", 32'(locked), 32'd1);
        chk("lock_fcount", 32'(frame_count), 32'd1);
        chk("lock_fstart", 32'(frame_start), 32'd1);
        chk("lock_ecount", 32'(err_count), 32'd0);
        cyc();
        chk("fstart_pulse", 32'(frame_start), 32'd0);

        // pixel recovery and visible-area boundaries
        run_to(9, 20);
        solid = 1'b1;
        scol = 12'hF0A;
        cyc();
        solid = 1'b0;
        cyc();
        chk_pix("pix_10_20", 1'b1, 10, 20, 12'hF0A);
        run_to(HV - 1, 20);
        cyc();
        chk_pix("pix_xlast", 1'b1, HV - 1, 20, pcol(HV - 1, 20));
        cyc();
        chk_pix("pix_xvis", 1'b0, HV, 20, pcol(HV, 20));
        run_to(5, VV - 1);
        cyc();
        chk_pix("pix_ylast", 1'b1, 5, VV - 1, pcol(5, VV - 1));
        run_to(5, VV);
        cyc();
        chk_pix("pix_yvis", 1'b0, 5, VV, pcol(5, VV));
        run_to(0, VV + VF);
        cyc();
        chk("frame2_fcount", 32'(frame_count), 32'd2);
        chk("frame2_fstart", 32'(frame_start), 32'd1);

        // two identical solid-colour frames
        run_to(LW - 1, LF - 1);
        solid = 1'b1;
        scol = 12'hF00;
        run_to(0, VV);
        cyc();
`ifdef VGA_MON_CRC_EN
        chk("crc1_valid", 32'(crc_valid), 32'd1);
        chk("crc1_value", 32'(frame_crc), 32'(crc_ref(HV * VV, 12'hF00)));
        cyc();
        chk("crc1_pulse", 32'(crc_valid), 32'd0);
`endif
        run_to(0, VV);
        cyc();
`ifdef VGA_MON_CRC_EN
        chk("crc2_valid", 32'(crc_valid), 32'd1);
        chk("crc2_value", 32'(frame_crc), 32'(crc_ref(HV * VV, 12'hF00)));
`endif
        solid = 1'b0;
        chk("frame3_fcount", 32'(frame_count), 32'd3);

        // one late hsync fall while locked
        hd_y = 5;
        run_to(HV + HF + 1, 5);
        chk("late_pre_locked", 32'(locked), 32'd1);
        chk("late_pre_serr", 32'(sync_err), 32'd0);
        cyc();
        chk("late_serr", 32'(sync_err), 32'd1);
        chk("late_ecount", 32'(err_count), 32'd1);
        chk("late_locked", 32'(locked), 32'd0);
        chk("late_fcount", 32'(frame_count), 32'd4);
        cyc();
        chk("late_serr_pulse", 32'(sync_err), 32'd0);
        run_to(LW - 1, 5);
        hd_y = -1;
        run_to(0, VV + VF);
        cyc();
        chk("relock1_acq", 32'(locked), 32'd0);
        run_to(0, VV + VF);
        cyc();
        chk("relock1", 32'(locked), 32'd1);
        chk("relock1_fcount", 32'(frame_count), 32'd5);
        chk("relock1_ecount", 32'(err_count), 32'd1);

        // hsync held high: timeout after 2*LW cycles without a fall
        run_to(LW - 1, 2);
        hhold = 1'b1;
        run_to(HV + HF, 4);
        chk("to_pre_locked", 32'(locked), 32'd1);
        chk("to_pre_serr", 32'(sync_err), 32'd0);
        cyc();
        chk("to_serr", 32'(sync_err), 32'd1);
        chk("to_locked", 32'(locked), 32'd0);
        chk("to_ecount", 32'(err_count), 32'd2);
        run_to(LW - 1, 4);
        hhold = 1'b0;
        run_to(0, VV + VF);
        run_to(0, VV + VF);
        cyc();
        chk("relock2", 32'(locked), 32'd1);
        chk("relock2_fcount", 32'(frame_count), 32'd6);

        // synchronous reset mid-frame while locked
        run_to(10, 10);
        rst = 1'b1;
        cyc();
        chk_zero("midrst");
        rst = 1'b0;
        run_to(0, VV + VF);
        cyc();
        chk("rst_acq", 32'(locked), 32'd0);
        run_to(0, VV + VF);
        cyc();
        chk("rst_relock", 32'(locked), 32'd1);
        chk("rst_relock_fcount", 32'(frame_count), 32'd1);
        chk("rst_relock_ecount", 32'(err_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_sync_monitor.md
Name: vga_sync_monitor

Overview:
- Receive-side counterpart of the 640x480 VGA timing/image path.
- Samples hsync/vsync/RGB in the pixel-clock domain, recovers pixel coordinates and locks to the incoming timing.
- Flags sync timing violations and reports per-frame statistics.
- Used as an on-chip loopback checker and as the capture front end for future video-input blocks.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- clk, in, 1: pixel clock, same domain as the source (no CDC)
- rst, in, 1: synchronous, active-high reset
- hsync_n, in, 1: active-low horizontal sync
- vsync_n, in, 1: active-low vertical sync
- r_in / g_in / b_in, in, 4 each: pixel colour
- pix_valid, out, 1: locked and recovered position inside the visible area
- pix_x, out, 10: recovered column
- pix_y, out, 9: recovered row
- pix_r / pix_g / pix_b, out, 4 each: registered colour, aligned with pix_x/pix_y
- locked, out, 1: FSM is in LOCKED
- frame_start, out, 1: one-cycle pulse on each vsync fall while locked
- frame_count, out, 16: frames seen while locked; wraps
- err_count, out, 8: timing errors seen while locked; saturates at 255
- sync_err, out, 1: one-cycle pulse per cycle with at least one error (any state except UNLOCKED)

Behaviour:
- Constants: WL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); WF = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525).
- Stage 1 registers all inputs. Edge detection compares stage 1 against the previous stage-1 value.
- Recovered counters x (0..WL-1) and y (0..WF-1) describe the stage-1 sample:
  - x increments every cycle and wraps WL-1 -> 0.
  - y increments on each x wrap and wraps WF-1 -> 0.
- Realignment, applied in every state, with the forced value taking priority over the increment in that cycle:
  - hsync fall forces x = H_VISIBLE+H_FRONT (656).
  - vsync fall forces y = V_VISIBLE+V_FRONT (490).
- Error checks use the predicted counter value (before any forced value):
  - hsync fall when predicted x != 656
  - hsync rise when x != 752
  - vsync fall when predicted y != 490
  - vsync rise when y != 492
  - timeout: no hsync fall for 2*WL cycles. The timeout counter clears on each hsync fall and after firing.
  - Multiple errors in the same cycle count as one error.
- FSM:
  - UNLOCKED -> ACQUIRE on a vsync fall, provided at least one hsync fall has occurred since entering UNLOCKED.
  - ACQUIRE -> LOCKED on the next vsync fall with no error during the frame.
  - ACQUIRE -> UNLOCKED on any error.
  - LOCKED -> UNLOCKED on any error; err_count increments in the same cycle.
- locked is registered: it deasserts the cycle after the error cycle.
- Output stage registers x, y, colour, pix_valid and frame_start. Latency from input pins to pix_* is 2 clocks.
- pix_valid = locked and x < H_VISIBLE and y < V_VISIBLE.
- frame_count increments on a vsync fall in LOCKED, including the fall that causes ACQUIRE -> LOCKED.
- Reset: all outputs 0, FSM = UNLOCKED, x = y = 0, counters cleared, edge history set to "high" so the first sample does not produce a false edge.
  - Reset mid-frame takes effect on the next edge of clk.
  - Relock requires at least one hsync fall and two vsync falls.

Optional Feature:
- Macro VGA_MON_CRC_EN. When defined:
  - Adds output frame_crc[15:0] and one-cycle pulse crc_valid.
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF), MSB-first, over {r,g,b} (12 bits per pixel) for every pix_valid pixel.
  - Latched to frame_crc and crc_valid pulsed on the first cycle with y == V_VISIBLE (480) while locked.
  - The accumulator reinitialises at the same point.
- When not defined: the ports do not exist and no CRC logic is built.

Decomposition:
- Package vga_timing_pkg holds:
  - the 640x480 timing constants and derived WL/WF
  - counter widths
  - the lock-state enum {UNLOCKED, ACQUIRE, LOCKED}
  - the CRC polynomial/init constants
- Sub-module vga_crc16: 12-bit-per-cycle CRC update with enable and init. Instantiated only under VGA_MON_CRC_EN.

Test Plan:
- Ideal 640x480 stream from reset: locked rises 1 clk after the 2nd vsync fall; frame_count=1 then +1 per frame; err_count=0.
- Locked, input pixel (x=10,y=20) with r=F,g=0,b=A: 2 clks later pix_valid=1, pix_x=10, pix_y=20, pix_r=F, pix_g=0, pix_b=A. Pixel (640,20) gives pix_valid=0.
- Locked, one hsync fall delayed 1 clk: sync_err pulse, err_count=1, locked=0 next clk; relock after two clean vsync falls.
- Locked, hsync_n held high for 1600 clks: timeout error at cycle 1600, locked=0, err_count +1.
- rst asserted mid-frame while locked: next clk all outputs 0; after release, relock on the 2nd vsync fall.
- VGA_MON_CRC_EN, two identical solid-colour frames (r=F,g=0,b=0): crc_valid pulses at y=480, frame_crc equal for both frames and matching the reference model value.
